// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 binary to BCD converter, five digits plus sign nibble.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits 5..2 with BLANK_CODE.
module bin_to_bcd_seq #(
  parameter int         WIDTH      = 16,
  parameter bit         SIGNED     = 1'b1,
  parameter logic [3:0] MINUS_CODE = 4'hA,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_d_out_1,
  output logic [3:0]       bcd_d_out_2,
  output logic [3:0]       bcd_d_out_3,
  output logic [3:0]       bcd_d_out_4,
  output logic [3:0]       bcd_d_out_5,
  output logic [3:0]       plus_minus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [4:0] LAST = 5'(WIDTH - 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d, mag_neg, mag_sh;
  logic [19:0]      acc_q, acc_d, adj, acc_sh, fmt, dig_q, dig_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d, done_q, done_d, busy_q, busy_d, din_neg;
  logic [3:0]       pm_q, pm_d;
  assign din_neg = SIGNED && din[WIDTH-1];
  assign mag_neg = ~din + 1'b1;
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 5; i++)
      adj[4*i+:4] = (acc_q[4*i+:4] >= 4'd5) ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
  end
  assign acc_sh = 20'({adj, mag_q[WIDTH-1]});
  assign mag_sh = {mag_q[WIDTH-2:0], 1'b0};
`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  // Units digit is never blanked so zero still reads as 0.
  always_comb begin
    fmt  = acc_sh;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      lead = lead && (acc_sh[4*i+:4] == 4'd0);
      if (lead) fmt[4*i+:4] = BLANK_CODE;
    end
  end
`else
  assign fmt = acc_sh;
`endif
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    dig_d   = dig_q;
    pm_d    = pm_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        busy_d  = 1'b1;
        mag_d   = din_neg ? mag_neg : din;
        neg_d   = din_neg;
        acc_d   = '0;
        cnt_d   = '0;
      end
      SHIFT: begin
        acc_d = acc_sh;
        mag_d = mag_sh;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          dig_d   = fmt;
          pm_d    = neg_q ? MINUS_CODE : BLANK_CODE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dig_q   <= '0;
      pm_q    <= BLANK_CODE;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dig_q   <= dig_d;
      pm_q    <= pm_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign bcd_d_out_1 = dig_q[3:0];
  assign bcd_d_out_2 = dig_q[7:4];
  assign bcd_d_out_3 = dig_q[11:8];
  assign bcd_d_out_4 = dig_q[15:12];
  assign bcd_d_out_5 = dig_q[19:16];
  assign plus_minus  = pm_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: checks signed and unsigned converters against an arithmetic decimal model.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] din = '0;
  logic busy_s, done_s, busy_u, done_u;
  logic [3:0] s1, s2, s3, s4, s5, sp, u1, u2, u3, u4, u5, up;
  logic [23:0] res_s, res_u;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  bin_to_bcd_seq #(.WIDTH(16), .SIGNED(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .busy(busy_s), .done(done_s),
    .bcd_d_out_1(s1), .bcd_d_out_2(s2), .bcd_d_out_3(s3), .bcd_d_out_4(s4),
    .bcd_d_out_5(s5), .plus_minus(sp));
  bin_to_bcd_seq #(.WIDTH(16), .SIGNED(1'b0)) u_u (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .busy(busy_u), .done(done_u),
    .bcd_d_out_1(u1), .bcd_d_out_2(u2), .bcd_d_out_3(u3), .bcd_d_out_4(u4),
    .bcd_d_out_5(u5), .plus_minus(up));
  assign res_s = {sp, s5, s4, s3, s2, s1};
  assign res_u = {up, u5, u4, u3, u2, u1};

  typedef struct {
    logic [15:0] din;
    logic [23:0] es;
    logic [23:0] eu;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decimal digits from plain division; sign and blanking from the display rules.
  function automatic logic [23:0] model(input logic [15:0] d, input bit sgn);
    int v, m;
    logic [23:0] r;
    bit lead;
    v = sgn ? int'($signed(d)) : int'(d);
    m = (v < 0) ? -v : v;
    r = '0;
    r[23:20] = (v < 0) ? 4'hA : 4'hF;
    for (int i = 0; i < 5; i++) begin
      r[4*i+:4] = 4'(m % 10);
      m = m / 10;
    end
    lead = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 4; i >= 1; i--) begin
      if (lead && r[4*i+:4] == 4'h0) r[4*i+:4] = 4'hF;
      else lead = 1'b0;
    end
`endif
    return r;
  endfunction

  task automatic convert(input logic [15:0] d, input string name);
    int n;
    bit stable;
    logic [23:0] prev_s, prev_u;
    prev_s = res_s;
    prev_u = res_u;
    stable = 1'b1;
    @(negedge clk);
    din = d;
    start = 1'b1;
    @(posedge clk); #1;
    chk({name, " busy_on"}, {30'd0, busy_s, busy_u}, 32'd3);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!done_s && (res_s !== prev_s || res_u !== prev_u)) stable = 1'b0;
    end while (!done_s && n < 40);
    chk({name, " latency"}, n, 16);
    chk({name, " done_both"}, {30'd0, done_s, done_u}, 32'd3);
    chk({name, " hold"}, {31'd0, stable}, 32'd1);
    chk({name, " signed"}, {8'd0, res_s}, {8'd0, model(d, 1'b1)});
    chk({name, " unsigned"}, {8'd0, res_u}, {8'd0, model(d, 1'b0)});
    @(posedge clk); #1;
    chk({name, " idle"}, {30'd0, done_s, busy_s}, 32'd0);
  endtask

  initial begin
    int ndone;
    bit saw;
`ifdef LEADING_ZERO_BLANK_EN
    tbl[0] = '{16'd1234,  24'hFF1234, 24'hFF1234};
    tbl[1] = '{16'hFFFF,  24'hAFFFF1, 24'hF65535};
    tbl[2] = '{16'h8000,  24'hA32768, 24'hF32768};
    tbl[3] = '{16'd0,     24'hFFFFF0, 24'hFFFFF0};
    tbl[4] = '{16'd10000, 24'hF10000, 24'hF10000};
    tbl[5] = '{16'd90,    24'hFFFF90, 24'hFFFF90};
`else
    tbl[0] = '{16'd1234,  24'hF01234, 24'hF01234};
    tbl[1] = '{16'hFFFF,  24'hA00001, 24'hF65535};
    tbl[2] = '{16'h8000,  24'hA32768, 24'hF32768};
    tbl[3] = '{16'd0,     24'hF00000, 24'hF00000};
    tbl[4] = '{16'd10000, 24'hF10000, 24'hF10000};
    tbl[5] = '{16'd90,    24'hF00090, 24'hF00090};
`endif
    #12;
    chk("reset_s", {6'd0, busy_s, done_s, res_s}, {8'd0, 24'hF00000});
    chk("reset_u", {6'd0, busy_u, done_u, res_u}, {8'd0, 24'hF00000});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      convert(tbl[i].din, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d_s", i), {8'd0, res_s}, {8'd0, tbl[i].es});
      chk($sformatf("tbl%0d_u", i), {8'd0, res_u}, {8'd0, tbl[i].eu});
    end
    // start during busy must be ignored and not queued
    @(negedge clk);
    din = 16'd1234;
    start = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i == 5) din = 16'd9;
      @(posedge clk); #1;
      if (done_s) ndone++;
    end
    chk("ignore_done_count", ndone, 1);
    chk("ignore_result", {8'd0, res_s}, {8'd0, model(16'd1234, 1'b1)});
    chk("ignore_idle", {31'd0, busy_s}, 32'd0);
    convert(16'd9, "after_ignore");
    // reset mid-shift aborts the conversion
    @(negedge clk);
    din = 16'd5000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_s", {6'd0, busy_s, done_s, res_s}, {8'd0, 24'hF00000});
    chk("abort_u", {6'd0, busy_u, done_u, res_u}, {8'd0, 24'hF00000});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_s || done_u || busy_s) saw = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw}, 32'd0);
    convert(16'd42, "after_abort");
    for (int j = 0; j < 25; j++)
      convert((j % 3 == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom), $sformatf("rnd%0d", j));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
